// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared definitions for the intersection phase scheduler: state codes,
// one-hot light encodings, default timing and the green-selection helper.
package intersection_phase_scheduler_pkg;

   // State codes double as the externally visible phase value.
   typedef enum logic [2:0] {
      ST_ALL_RED   = 3'd0,
      ST_NS_GREEN  = 3'd1,
      ST_NS_YELLOW = 3'd2,
      ST_EW_GREEN  = 3'd3,
      ST_EW_YELLOW = 3'd4,
      ST_PED_WALK  = 3'd5
   } state_e;

   // One-hot light encodings, bit order {R,Y,G}.
   localparam logic [2:0] LIGHT_RED = 3'b100;
   localparam logic [2:0] LIGHT_YEL = 3'b010;
   localparam logic [2:0] LIGHT_GRN = 3'b001;

   // Default timing, all in ticks.
   localparam int DEF_CNT_W     = 8;
   localparam int DEF_GREEN_MIN = 4;
   localparam int DEF_GREEN_MAX = 10;
   localparam int DEF_YELLOW_T  = 2;
   localparam int DEF_ALLRED_T  = 1;
   localparam int DEF_PED_T     = 5;

   // Choose the next green: the direction not served last, unless it has no
   // demand and the other one does. With no demand at all, alternate anyway.
   function automatic state_e pick_green(input logic last_ew,
                                         input logic ns_pend,
                                         input logic ew_pend);
      state_e nxt;
      if (last_ew) begin
         nxt = (!ns_pend && ew_pend) ? ST_EW_GREEN : ST_NS_GREEN;
      end else begin
         nxt = (!ew_pend && ns_pend) ? ST_NS_GREEN : ST_EW_GREEN;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/intersection_phase_scheduler_req_sync.sv
// Two-flop synchronizer for an asynchronous request level, with an optional
// rising-edge pulse taken after the second flop.
module req_sync #(
   parameter bit EDGE_EN = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic level_o,
   output logic pulse_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage metastability filter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign level_o = sync_q;

   generate
      if (EDGE_EN) begin : g_edge
         logic prev_q;

         // Delayed copy of the synced level for edge detection.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               prev_q <= 1'b0;
            end else begin
               prev_q <= sync_q;
            end
         end

         assign pulse_o = sync_q & ~prev_q;
      end else begin : g_no_edge
         assign pulse_o = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Traffic-light phase scheduler for a two-way intersection with an optional
// pedestrian walk phase. Build option: define PED_PHASE_EN to enable the
// pedestrian path (PED_WALK state, walk and ped_ack outputs). Without it the
// ped_req input is ignored and walk/ped_ack are held at 0.
module intersection_phase_scheduler
   import intersection_phase_scheduler_pkg::*;
#(
   parameter int CNT_W     = DEF_CNT_W,
   parameter int GREEN_MIN = DEF_GREEN_MIN,
   parameter int GREEN_MAX = DEF_GREEN_MAX,
   parameter int YELLOW_T  = DEF_YELLOW_T,
   parameter int ALLRED_T  = DEF_ALLRED_T,
   parameter int PED_T     = DEF_PED_T
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       car_ns,
   input  logic       car_ew,
   input  logic       ped_req,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk,
   output logic       ped_ack,
   output logic [2:0] phase
);

   // Terminal timer values: a phase of T ticks leaves on the tick where timer==T-1.
   localparam logic [CNT_W-1:0] GMIN_END   = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] GMAX_END   = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] ALLRED_END = CNT_W'(ALLRED_T - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             ns_pend_q, ns_pend_d;
   logic             ew_pend_q, ew_pend_d;
   logic             last_ew_q, last_ew_d;
   logic [2:0]       ns_light_q, ns_light_d;
   logic [2:0]       ew_light_q, ew_light_d;

   logic car_ns_s;
   logic car_ew_s;
   logic ns_pulse_unused;
   logic ew_pulse_unused;
   logic ped_pend_w;
   logic enter_ns;
   logic enter_ew;
   logic ns_exit;
   logic ew_exit;

   req_sync #(.EDGE_EN(1'b0)) u_sync_ns (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (car_ns),
      .level_o (car_ns_s),
      .pulse_o (ns_pulse_unused)
   );

   req_sync #(.EDGE_EN(1'b0)) u_sync_ew (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (car_ew),
      .level_o (car_ew_s),
      .pulse_o (ew_pulse_unused)
   );

`ifdef PED_PHASE_EN
   localparam logic [CNT_W-1:0] PED_END = CNT_W'(PED_T - 1);

   logic ped_level_unused;
   logic ped_rise;
   logic ped_pend_q, ped_pend_d;
   logic walk_q, walk_d;
   logic ped_ack_q, ped_ack_d;
   logic enter_ped;

   req_sync #(.EDGE_EN(1'b1)) u_sync_ped (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (ped_req),
      .level_o (ped_level_unused),
      .pulse_o (ped_rise)
   );

   assign enter_ped  = (state_d == ST_PED_WALK) && (state_q != ST_PED_WALK);
   assign ped_pend_w = ped_pend_q;

   // A press coinciding with walk entry is served by that walk, so clear wins.
   always_comb begin
      ped_pend_d = ped_pend_q | ped_rise;
      if (enter_ped) begin
         ped_pend_d = 1'b0;
      end
      walk_d    = (state_d == ST_PED_WALK);
      ped_ack_d = enter_ped;
   end

   // Pedestrian request flag and registered walk outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ped_pend_q <= 1'b0;
         walk_q     <= 1'b0;
         ped_ack_q  <= 1'b0;
      end else begin
         ped_pend_q <= ped_pend_d;
         walk_q     <= walk_d;
         ped_ack_q  <= ped_ack_d;
      end
   end

   assign walk    = walk_q;
   assign ped_ack = ped_ack_q;
`else
   logic ped_req_unused;

   assign ped_req_unused = ped_req;
   assign ped_pend_w     = 1'b0;
   assign walk           = 1'b0;
   assign ped_ack        = 1'b0;
`endif

   // Green leaves early once minimum time is met and own road is empty, or
   // at maximum time regardless; either way only when someone else waits.
   assign ns_exit = tick && (ew_pend_q || ped_pend_w) &&
                    (((timer_q >= GMIN_END) && !car_ns_s) || (timer_q == GMAX_END));
   assign ew_exit = tick && (ns_pend_q || ped_pend_w) &&
                    (((timer_q >= GMIN_END) && !car_ew_s) || (timer_q == GMAX_END));

   // Next-state selection for the phase FSM.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ALL_RED: begin
            if (tick && (timer_q == ALLRED_END)) begin
`ifdef PED_PHASE_EN
               if (ped_pend_q) begin
                  state_d = ST_PED_WALK;
               end else begin
                  state_d = pick_green(last_ew_q, ns_pend_q, ew_pend_q);
               end
`else
               state_d = pick_green(last_ew_q, ns_pend_q, ew_pend_q);
`endif
            end
         end
         ST_NS_GREEN: begin
            if (ns_exit) begin
               state_d = ST_NS_YELLOW;
            end
         end
         ST_NS_YELLOW: begin
            if (tick && (timer_q == YELLOW_END)) begin
               state_d = ST_ALL_RED;
            end
         end
         ST_EW_GREEN: begin
            if (ew_exit) begin
               state_d = ST_EW_YELLOW;
            end
         end
         ST_EW_YELLOW: begin
            if (tick && (timer_q == YELLOW_END)) begin
               state_d = ST_ALL_RED;
            end
         end
`ifdef PED_PHASE_EN
         ST_PED_WALK: begin
            if (tick && (timer_q == PED_END)) begin
               state_d = pick_green(last_ew_q, ns_pend_q, ew_pend_q);
            end
         end
`endif
         default: state_d = ST_ALL_RED;
      endcase
   end

   assign enter_ns = (state_d == ST_NS_GREEN) && (state_q != ST_NS_GREEN);
   assign enter_ew = (state_d == ST_EW_GREEN) && (state_q != ST_EW_GREEN);

   // Timer, demand flags, last-served direction and registered light values.
   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q) begin
         timer_d = '0;
      end else if (tick && (timer_q != '1)) begin
         timer_d = timer_q + 1'b1;
      end

      ns_pend_d = ns_pend_q | car_ns_s;
      if (enter_ns) begin
         ns_pend_d = 1'b0;
      end
      ew_pend_d = ew_pend_q | car_ew_s;
      if (enter_ew) begin
         ew_pend_d = 1'b0;
      end

      last_ew_d = last_ew_q;
      if (enter_ns) begin
         last_ew_d = 1'b0;
      end else if (enter_ew) begin
         last_ew_d = 1'b1;
      end

      ns_light_d = LIGHT_RED;
      ew_light_d = LIGHT_RED;
      case (state_d)
         ST_NS_GREEN:  ns_light_d = LIGHT_GRN;
         ST_NS_YELLOW: ns_light_d = LIGHT_YEL;
         ST_EW_GREEN:  ew_light_d = LIGHT_GRN;
         ST_EW_YELLOW: ew_light_d = LIGHT_YEL;
         default: begin
            ns_light_d = LIGHT_RED;
            ew_light_d = LIGHT_RED;
         end
      endcase
   end

   // State and datapath registers; reset starts at ALL_RED with N/S next.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_ALL_RED;
         timer_q    <= '0;
         ns_pend_q  <= 1'b0;
         ew_pend_q  <= 1'b0;
         last_ew_q  <= 1'b1;
         ns_light_q <= LIGHT_RED;
         ew_light_q <= LIGHT_RED;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         ns_pend_q  <= ns_pend_d;
         ew_pend_q  <= ew_pend_d;
         last_ew_q  <= last_ew_d;
         ns_light_q <= ns_light_d;
         ew_light_q <= ew_light_d;
      end
   end

   assign ns_light = ns_light_q;
   assign ew_light = ew_light_q;
   assign phase    = state_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with tick asserted every
// clock. Expected values are hand-derived cycle by cycle from reset release.
module tb_intersection_phase_scheduler;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic       car_ns;
   logic       car_ew;
   logic       ped_req;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       walk;
   logic       ped_ack;
   logic [2:0] phase;

   int passed;
   int total;

   intersection_phase_scheduler dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .car_ns   (car_ns),
      .car_ew   (car_ew),
      .ped_req  (ped_req),
      .ns_light (ns_light),
      .ew_light (ew_light),
      .walk     (walk),
      .ped_ack  (ped_ack),
      .phase    (phase)
   );

   // Clock: 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 unit past the edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
      end
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_phase"}, 8'(phase), 8'd0);
      check({tag, "_ns"}, 8'(ns_light), 8'(RED));
      check({tag, "_ew"}, 8'(ew_light), 8'(RED));
      check({tag, "_walk"}, 8'(walk), 8'd0);
      check({tag, "_ack"}, 8'(ped_ack), 8'd0);
   endtask

   // Directed sequence; edge labels En count rising edges since reset release.
   initial begin
      passed  = 0;
      total   = 0;
      rst_n   = 1'b0;
      tick    = 1'b1;
      car_ns  = 1'b0;
      car_ew  = 1'b0;
      ped_req = 1'b0;

      step(3);
      check_reset_outputs("rst");

      // Idle release: one tick of ALL_RED, then N/S green held indefinitely.
      rst_n = 1'b1;
      step(1);
      check("idle_e1_phase", 8'(phase), 8'd1);
      check("idle_e1_ns", 8'(ns_light), 8'(GRN));
      check("idle_e1_ew", 8'(ew_light), 8'(RED));
      for (int i = 0; i < 50; i++) begin
         step(1);
         check("idle_hold_phase", 8'(phase), 8'd1);
         check("idle_hold_ew", 8'(ew_light), 8'(RED));
      end

      // E/W demand pulsed at N/S green timer 0: 4 green, 2 yellow, 1 all-red.
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);                      // E1
      check("min_e1_phase", 8'(phase), 8'd1);
      car_ew = 1'b1;
      step(2);                      // E3
      car_ew = 1'b0;
      step(1);                      // E4
      check("min_e4_phase", 8'(phase), 8'd1);
      check("min_e4_ewpend", 8'(dut.ew_pend_q), 8'd1);
      step(1);                      // E5
      check("min_e5_phase", 8'(phase), 8'd2);
      check("min_e5_ns", 8'(ns_light), 8'(YEL));
      check("min_e5_ew", 8'(ew_light), 8'(RED));
      step(1);                      // E6
      check("min_e6_phase", 8'(phase), 8'd2);
      step(1);                      // E7
      check("min_e7_phase", 8'(phase), 8'd0);
      check("min_e7_ns", 8'(ns_light), 8'(RED));
      step(1);                      // E8
      check("min_e8_phase", 8'(phase), 8'd3);
      check("min_e8_ew", 8'(ew_light), 8'(GRN));
      check("min_e8_ns", 8'(ns_light), 8'(RED));
      check("min_e8_ewpend", 8'(dut.ew_pend_q), 8'd0);

      // Both sensors held: N/S green only yields at GREEN_MAX (10 ticks).
      car_ns = 1'b1;
      car_ew = 1'b1;
      rst_n  = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);                      // E1
      check("max_e1_phase", 8'(phase), 8'd1);
      step(4);                      // E5: min reached but own sensor set
      check("max_e5_phase", 8'(phase), 8'd1);
      step(5);                      // E10
      check("max_e10_phase", 8'(phase), 8'd1);
      step(1);                      // E11
      check("max_e11_phase", 8'(phase), 8'd2);
      check("max_e11_ns", 8'(ns_light), 8'(YEL));
      step(2);                      // E13
      check("max_e13_phase", 8'(phase), 8'd0);
      step(1);                      // E14
      check("max_e14_phase", 8'(phase), 8'd3);
      check("max_e14_ew", 8'(ew_light), 8'(GRN));
      car_ns = 1'b0;
      car_ew = 1'b0;

`ifdef PED_PHASE_EN
      // Press during E/W green; second press lands on walk entry and is absorbed.
      ped_req = 1'b1;
      step(2);                      // E16
      ped_req = 1'b0;
      step(2);                      // E18
      check("ped_e18_phase", 8'(phase), 8'd4);
      check("ped_e18_ew", 8'(ew_light), 8'(YEL));
      ped_req = 1'b1;
      step(2);                      // E20
      check("ped_e20_phase", 8'(phase), 8'd0);
      check("ped_e20_pend", 8'(dut.ped_pend_q), 8'd1);
      step(1);                      // E21: walk entry
      check("ped_e21_phase", 8'(phase), 8'd5);
      check("ped_e21_walk", 8'(walk), 8'd1);
      check("ped_e21_ack", 8'(ped_ack), 8'd1);
      check("ped_e21_ns", 8'(ns_light), 8'(RED));
      check("ped_e21_ew", 8'(ew_light), 8'(RED));
      check("ped_e21_pend_absorbed", 8'(dut.ped_pend_q), 8'd0);
      step(1);                      // E22
      check("ped_e22_ack", 8'(ped_ack), 8'd0);
      check("ped_e22_walk", 8'(walk), 8'd1);
      step(3);                      // E25
      check("ped_e25_phase", 8'(phase), 8'd5);
      check("ped_e25_walk", 8'(walk), 8'd1);
      step(1);                      // E26
      check("ped_e26_phase", 8'(phase), 8'd1);
      check("ped_e26_walk", 8'(walk), 8'd0);
      check("ped_e26_ns", 8'(ns_light), 8'(GRN));
      ped_req = 1'b0;
      step(4);                      // E30
      check("ped_e30_phase", 8'(phase), 8'd2);
      step(2);                      // E32
      check("ped_e32_phase", 8'(phase), 8'd0);
      step(1);                      // E33: no repeat walk
      check("ped_e33_phase", 8'(phase), 8'd3);
      check("ped_e33_walk", 8'(walk), 8'd0);
      car_ns = 1'b1;
      step(4);                      // E37
      check("ped_e37_phase", 8'(phase), 8'd4);
      check("ped_e37_ew", 8'(ew_light), 8'(YEL));
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      step(2);
      check_reset_outputs("midrst_hold");
`else
      // Ped ignored: E/W yields to pending N/S demand; reset mid-yellow.
      ped_req = 1'b1;
      step(2);                      // E16
      ped_req = 1'b0;
      step(2);                      // E18
      check("noped_e18_phase", 8'(phase), 8'd4);
      check("noped_e18_ew", 8'(ew_light), 8'(YEL));
      check("noped_e18_walk", 8'(walk), 8'd0);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      step(1);
      car_ns = 1'b1;
      car_ew = 1'b1;
      rst_n  = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (i < 20) begin
            ped_req = ~ped_req;
         end
         step(1);
         check("noped_walk", 8'(walk), 8'd0);
         check("noped_ack", 8'(ped_ack), 8'd0);
         check("noped_not_walk_phase", 8'(phase == 3'd5), 8'd0);
      end
      check("noped_e40_phase", 8'(phase), 8'd3);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/intersection_phase_scheduler.md
INTERSECTION_PHASE_SCHEDULER -- requirements
Module: intersection_phase_scheduler

Interface
REQ-001 Params SHALL be: CNT_W 8, tick-counter width; GREEN_MIN 4, min green ticks; GREEN_MAX 10, max green ticks under opposing demand; YELLOW_T 2; ALLRED_T 1; PED_T 5, walk ticks.
REQ-002 Ports SHALL be: clk in 1, single clock (posedge); rst_n in 1, asynchronous active-low reset.
REQ-003 tick in 1, synchronous one-cycle timebase strobe; car_ns in 1, async N/S sensor level; car_ew in 1, async E/W sensor level; ped_req in 1, async pedestrian button.
REQ-004 ns_light out 3, one-hot {R,Y,G}; ew_light out 3, one-hot {R,Y,G}; walk out 1; ped_ack out 1, one-cycle pulse; phase out 3, state encoding.

Function
REQ-005 Each async input SHALL pass a 2-flop synchronizer; ped_req SHALL also be rising-edge detected, so latency from input change to pending update is exactly 3 clk.
REQ-006 Pending flags ns_pend/ew_pend SHALL set on any cycle where the synced level is 1, and clear on entry to their own green; when set and clear coincide, clear wins.
REQ-007 ped_pend SHALL set on a synced ped rising edge and clear on entry to PED_WALK; when set and clear coincide, clear wins, because the press is served by this walk.
REQ-008 FSM states SHALL be ALL_RED (0), NS_GREEN (1), NS_YELLOW (2), EW_GREEN (3), EW_YELLOW (4), PED_WALK (5); phase SHALL equal the state code.
REQ-009 The timer SHALL advance only on tick, restart at 0 on every state entry, and saturate at 2^CNT_W-1.
REQ-010 Fixed states SHALL last exactly T ticks: the transition occurs on the tick where timer==T-1. T is YELLOW_T for yellow, ALLRED_T for ALL_RED and PED_T for PED_WALK.
REQ-011 Green SHALL exit to yellow on a tick when timer>=GREEN_MIN-1 and there is opposing demand (other-direction pend or ped_pend) and own synced sensor is 0.
REQ-012 Green SHALL also exit to yellow on a tick when timer==GREEN_MAX-1 and there is opposing demand, regardless of own sensor.
REQ-013 With no opposing demand, green SHALL hold indefinitely.
REQ-014 Yellow SHALL always go to ALL_RED.
REQ-015 ALL_RED exit SHALL be decided in priority order: (1) ped_pend → PED_WALK; (2) otherwise the direction not served last; (3) if that direction has no pend and the other does, go to the other.
REQ-016 If ALL_RED exits with no pending demand at all, the next state SHALL be the direction not served last.
REQ-017 PED_WALK exit SHALL follow the same rule as ALL_RED, excluding ped_pend.
REQ-018 Outputs SHALL be registered. Red is driven in every state except own green and own yellow. walk=1 only in PED_WALK. ped_ack SHALL pulse on the cycle after entry to PED_WALK.
REQ-019 At most one direction SHALL be non-red at any cycle, and walk=1 SHALL imply both directions red.

Reset
REQ-020 While rst_n=0, the block SHALL be in state ALL_RED, and last-served SHALL point to EW so that N/S goes first.
REQ-021 While rst_n=0, timer and all pend flags SHALL be 0, both lights SHALL be red (3'b100), walk=0, ped_ack=0 and the sync flops SHALL be 0.
REQ-022 Reset asserted mid-phase SHALL take effect immediately, with no yellow; deassertion SHALL be synchronous to clk via the external reset synchronizer.

Configuration
REQ-023 Macro PED_PHASE_EN defined: the ped path, PED_WALK state and walk/ped_ack outputs SHALL be functional.
REQ-024 PED_PHASE_EN undefined: ped_req SHALL be ignored, walk=0 and ped_ack=0 constant, ped_pend and PED_WALK SHALL be absent, and ped_pend SHALL be treated as 0 in REQ-011, REQ-012 and REQ-015.
REQ-025 Port list SHALL be identical with or without PED_PHASE_EN.

Structure
REQ-026 Shared package SHALL hold state codes, the light encodings RED/YEL/GRN and the default timing constants.
REQ-027 One sub-module SHALL exist: req_sync, a 2-flop synchronizer plus optional rising-edge pulse output, instantiated three times.

Verification (tick every clk, default params, PED_PHASE_EN defined)
REQ-028 Reset release, no inputs → 1 tick ALL_RED, then NS_GREEN held for 50 ticks; ew_light=100 throughout.
REQ-029 car_ew=1 pulsed 2 clk during NS_GREEN timer 0, car_ns=0 → NS green 4 ticks, yellow 2, ALL_RED 1, then EW_GREEN; ew_pend cleared on entry.
REQ-030 car_ns held 1 and car_ew=1 → NS green lasts exactly 10 ticks (GREEN_MAX), then yellow.
REQ-031 ped_req rising during EW_GREEN → after yellow and all-red, PED_WALK 5 ticks with walk=1, both red, ped_ack one pulse, then NS_GREEN.
REQ-032 Second ped press inside the walk-entry cycle is absorbed (no repeat walk); rst_n low mid-EW_YELLOW → all outputs at reset values in the same cycle.
REQ-033 PED_PHASE_EN undefined: ped_req toggled 20 times → walk, ped_ack stay 0 and phase never equals 5.
